// File: rtl/dct_da_mac_z1_if.sv
// Bundle for the Z1 DA engine: sample input stream, coefficient ROM port and result stream.
interface dct_da_mac_z1_if #(
    parameter int W     = 16,
    parameter int ACC_W = W + 17
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     u0;
    logic signed [W-1:0]     u1;
    logic signed [W-1:0]     u2;
    logic signed [W-1:0]     u3;
    logic                    rom_cs;
    logic [2:0]              rom_addr;
    logic [16:0]             rom_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] z;

    modport slave (
        input  in_valid, u0, u1, u2, u3, rom_data, out_ready,
        output in_ready, rom_cs, rom_addr, out_valid, z
    );

    modport master (
        output in_valid, u0, u1, u2, u3, rom_data, out_ready,
        input  in_ready, rom_cs, rom_addr, out_valid, z
    );
endinterface

// File: rtl/dct_da_mac_z1.sv
// Bit-serial distributed-arithmetic MAC for DCT output Z1 = c7*u0 + c5*u1 + c3*u2 + c1*u3,
// walking input bit-planes MSB first against a half-symmetric 8-entry coefficient ROM.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready high
// ACC   | W cycles, one bit-plane per cycle through the ROM
// OFS   | one cycle, subtract the R0 offset entry and load z
// DONE  | z presented with out_valid until out_ready
module dct_da_mac_z1 #(
    parameter int W     = 16,
    parameter int ACC_W = W + 17
) (
    input  logic            clk,
    input  logic            rst,
    dct_da_mac_z1_if.slave  bus
);
    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OFS  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]              state;
    logic [W-1:0]            sh0, sh1, sh2, sh3;
    logic [CW-1:0]           cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] z_q;
    logic signed [ACC_W-1:0] rom_ext;
    logic signed [ACC_W-1:0] r_term;
    logic [3:0]              nib;
    logic [2:0]              addr;
    logic                    rom_unused;

    assign nib = {sh0[W-1], sh1[W-1], sh2[W-1], sh3[W-1]};

    // Only half the table is stored; the u0 bit selects the mirrored entry and negates it.
    assign addr    = nib[3] ? ~nib[2:0] : nib[2:0];
    assign rom_ext = {{(ACC_W-16){bus.rom_data[15]}}, bus.rom_data[15:0]};
    assign r_term  = nib[3] ? -rom_ext : rom_ext;

    assign rom_unused = bus.rom_data[16];

    assign bus.rom_cs    = (state == S_ACC) || (state == S_OFS);
    assign bus.rom_addr  = (state == S_ACC) ? addr : 3'b000;
    assign bus.in_ready  = (state == S_IDLE) && !rst;
    assign bus.out_valid = (state == S_DONE);
    assign bus.z         = z_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sh0   <= '0;
            sh1   <= '0;
            sh2   <= '0;
            sh3   <= '0;
            cnt   <= '0;
            acc   <= '0;
            z_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        sh0   <= bus.u0;
                        sh1   <= bus.u1;
                        sh2   <= bus.u2;
                        sh3   <= bus.u3;
                        cnt   <= CW'(W - 1);
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    // The sign-bit plane enters positively; every lower plane is subtracted.
                    if (cnt == CW'(W - 1)) begin
                        acc <= r_term;
                    end else begin
                        acc <= (acc <<< 1) - r_term;
                    end
                    sh0 <= sh0 << 1;
                    sh1 <= sh1 << 1;
                    sh2 <= sh2 << 1;
                    sh3 <= sh3 << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= S_OFS;
                    end
                end
                S_OFS: begin
                    z_q   <= acc - rom_ext;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dct_da_mac_z1.sv
// Directed bench for dct_da_mac_z1: models the Z1 coefficient ROM and checks results,
// latency, ROM access pattern, backpressure and mid-operation reset against hand-computed values.
module tb_dct_da_mac_z1;
    localparam int W     = 16;
    localparam int ACC_W = W + 17;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [2:0] addr_log [0:31];
    logic signed [15:0] rom_val;

    dct_da_mac_z1_if #(.W(W), .ACC_W(ACC_W)) bus ();

    dct_da_mac_z1 #(.W(W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Half-table of floor(2^14 * (c7 +/- c5 +/- c3 +/- c1) / 2); bit 16 set to prove it is ignored.
    always_comb begin
        rom_val = 16'sd0;
        case (bus.rom_addr)
            3'd0:    rom_val = 16'sd20995;
            3'd1:    rom_val = 16'sd4926;
            3'd2:    rom_val = 16'sd7372;
            3'd3:    rom_val = -16'sd8697;
            3'd4:    rom_val = 16'sd11892;
            3'd5:    rom_val = -16'sd4177;
            3'd6:    rom_val = -16'sd1730;
            default: rom_val = -16'sd17800;
        endcase
        bus.rom_data = {1'b1, rom_val};
    end

    task automatic do_sample(input logic signed [15:0] a0, input logic signed [15:0] a1,
                             input logic signed [15:0] a2, input logic signed [15:0] a3,
                             output logic signed [ACC_W-1:0] zo, output int lat, output int cs_n);
        int guard;
        @(negedge clk);
        bus.u0 = a0; bus.u1 = a1; bus.u2 = a2; bus.u3 = a3;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat  = -1;
        cs_n = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (k < 32) addr_log[k] = bus.rom_addr;
            if (bus.rom_cs) cs_n++;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        zo = bus.z;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.z !== '0) begin n_fail++; $display("FAIL reset_z: got %0d expected 0", bus.z); end
        n_checks++;
        if (bus.rom_cs !== 1'b0 || bus.rom_addr !== 3'b000) begin
            n_fail++; $display("FAIL reset_rom: got cs=%b addr=%0d expected cs=0 addr=0", bus.rom_cs, bus.rom_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_zero();
        logic signed [ACC_W-1:0] zo;
        int lat, cs_n;
        do_sample(16'sd0, 16'sd0, 16'sd0, 16'sd0, zo, lat, cs_n);
        n_checks++;
        if (zo !== 33'sd0) begin n_fail++; $display("FAIL zero_z: got %0d expected 0", zo); end
        n_checks++;
        if (lat != 18) begin n_fail++; $display("FAIL zero_latency: got %0d expected 18", lat); end
        n_checks++;
        if (cs_n != 17) begin n_fail++; $display("FAIL zero_rom_cs_count: got %0d expected 17", cs_n); end
    endtask

    task automatic test_all_ones();
        logic signed [ACC_W-1:0] zo;
        logic signed [ACC_W-1:0] ex;
        int lat, cs_n;
        ex = -41990;
        do_sample(-16'sd1, -16'sd1, -16'sd1, -16'sd1, zo, lat, cs_n);
        n_checks++;
        if (zo !== ex) begin n_fail++; $display("FAIL all_ones_z: got %0d expected %0d", zo, ex); end
        n_checks++;
        if (lat != 18) begin n_fail++; $display("FAIL all_ones_latency: got %0d expected 18", lat); end
    endtask

    task automatic test_single();
        logic signed [ACC_W-1:0] zo;
        logic signed [ACC_W-1:0] ex;
        int lat, cs_n;
        do_sample(16'sd0, 16'sd0, 16'sd0, 16'sd1, zo, lat, cs_n);
        ex = 16069;
        n_checks++;
        if (zo !== ex) begin n_fail++; $display("FAIL single_u3_z: got %0d expected %0d", zo, ex); end
        do_sample(16'sd1, 16'sd0, 16'sd0, 16'sd0, zo, lat, cs_n);
        ex = 3195;
        n_checks++;
        if (zo !== ex) begin n_fail++; $display("FAIL single_u0_z: got %0d expected %0d", zo, ex); end
        do_sample(16'sd0, 16'sd0, 16'sd0, 16'sh8000, zo, lat, cs_n);
        ex = -526548992;
        n_checks++;
        if (zo !== ex) begin n_fail++; $display("FAIL single_u3_min_z: got %0d expected %0d", zo, ex); end
    endtask

    task automatic test_rom_protocol();
        logic signed [ACC_W-1:0] zo;
        logic signed [ACC_W-1:0] ex;
        int lat, cs_n, bad;
        do_sample(-16'sd1, 16'sd0, 16'sd0, 16'sd0, zo, lat, cs_n);
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            if (addr_log[k] !== 3'b111) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rom_acc_addr: got %0d cycles off 7 expected 0", bad); end
        n_checks++;
        if (addr_log[17] !== 3'b000) begin n_fail++; $display("FAIL rom_ofs_addr: got %0d expected 0", addr_log[17]); end
        n_checks++;
        if (cs_n != 17) begin n_fail++; $display("FAIL rom_cs_count: got %0d expected 17", cs_n); end
        ex = -3195;
        n_checks++;
        if (zo !== ex) begin n_fail++; $display("FAIL rom_u0_neg_z: got %0d expected %0d", zo, ex); end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] su [0:2][0:3];
        logic signed [ACC_W-1:0] ex [0:2];
        logic signed [ACC_W-1:0] held;
        int acc_t [0:2];
        int n_in, n_out, stall, extra;
        logic accept_now;
        su[0][0] = 16'sd0;  su[0][1] = 16'sd0;  su[0][2] = 16'sd0;  su[0][3] = 16'sd1;
        su[1][0] = 16'sd1;  su[1][1] = 16'sd0;  su[1][2] = 16'sd0;  su[1][3] = 16'sd0;
        su[2][0] = -16'sd1; su[2][1] = -16'sd1; su[2][2] = -16'sd1; su[2][3] = -16'sd1;
        ex[0] = 16069; ex[1] = 3195; ex[2] = -41990;
        acc_t[0] = 0; acc_t[1] = 0; acc_t[2] = 0;
        n_in = 0; n_out = 0; stall = 0; held = '0;
        @(negedge clk);
        bus.u0 = su[0][0]; bus.u1 = su[0][1]; bus.u2 = su[0][2]; bus.u3 = su[0][3];
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 200 && n_out < 3; t++) begin
            if (bus.out_valid) begin
                if (n_out == 1 && stall < 5) begin
                    if (stall == 0) begin
                        held = bus.z;
                    end else begin
                        n_checks++;
                        if (bus.z !== held) begin n_fail++; $display("FAIL b2b_z_held: got %0d expected %0d", bus.z, held); end
                    end
                    n_checks++;
                    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready: got %b expected 0", bus.in_ready); end
                    stall++;
                    bus.out_ready = 1'b0;
                end else begin
                    n_checks++;
                    if (bus.z !== ex[n_out]) begin
                        n_fail++; $display("FAIL b2b_z_%0d: got %0d expected %0d", n_out, bus.z, ex[n_out]);
                    end
                    n_out++;
                    bus.out_ready = 1'b1;
                end
            end else begin
                bus.out_ready = 1'b1;
            end
            accept_now = bus.in_valid && bus.in_ready;
            @(posedge clk);
            @(negedge clk);
            if (accept_now) begin
                acc_t[n_in] = t;
                n_in++;
                if (n_in < 3) begin
                    bus.u0 = su[n_in][0]; bus.u1 = su[n_in][1]; bus.u2 = su[n_in][2]; bus.u3 = su[n_in][3];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        n_checks++;
        if (n_out != 3 || n_in != 3) begin n_fail++; $display("FAIL b2b_count: got in=%0d out=%0d expected 3 and 3", n_in, n_out); end
        n_checks++;
        if (acc_t[1] - acc_t[0] != 19) begin n_fail++; $display("FAIL b2b_throughput: got %0d expected 19", acc_t[1] - acc_t[0]); end
        n_checks++;
        if (acc_t[2] - acc_t[1] != 24) begin n_fail++; $display("FAIL b2b_stalled_spacing: got %0d expected 24", acc_t[2] - acc_t[1]); end
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        n_checks++;
        if (extra != 0) begin n_fail++; $display("FAIL b2b_duplicate: got %0d valid cycles expected 0", extra); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic signed [ACC_W-1:0] zo;
        logic signed [ACC_W-1:0] ex;
        int lat, cs_n, seen;
        @(negedge clk);
        bus.u0 = 16'sd0; bus.u1 = 16'sd0; bus.u2 = 16'sd0; bus.u3 = 16'sd1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_handshake: got in_ready=%b out_valid=%b expected 0 0", bus.in_ready, bus.out_valid);
        end
        n_checks++;
        if (bus.rom_cs !== 1'b0 || bus.rom_addr !== 3'b000) begin
            n_fail++; $display("FAIL midrst_rom: got cs=%b addr=%0d expected 0 0", bus.rom_cs, bus.rom_addr);
        end
        n_checks++;
        if (bus.z !== '0) begin n_fail++; $display("FAIL midrst_z: got %0d expected 0", bus.z); end
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
        do_sample(16'sd0, 16'sd0, 16'sd0, 16'sh8000, zo, lat, cs_n);
        ex = -526548992;
        n_checks++;
        if (zo !== ex) begin n_fail++; $display("FAIL midrst_fresh_z: got %0d expected %0d", zo, ex); end
        n_checks++;
        if (lat != 18) begin n_fail++; $display("FAIL midrst_fresh_latency: got %0d expected 18", lat); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.u0 = '0; bus.u1 = '0; bus.u2 = '0; bus.u3 = '0;
        for (int i = 0; i < 32; i++) addr_log[i] = 3'b000;
        test_reset();
        test_zero();
        test_all_ones();
        test_single();
        test_rom_protocol();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
